// File: rtl/cam_update_ctrl.sv
// rtl/cam_update_ctrl.sv - serialises fill/invalidate/flush updates to a small CAM
// Keeps a shadow valid vector and picks victims: lowest free slot, else round-robin.
module cam_update_ctrl #(
  parameter int NUM_ENTRIES = 4,
  parameter int KEY_WIDTH   = 32,
  parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill_req,
  input  logic [KEY_WIDTH-1:0]   fill_key,
  output logic                   fill_ack,
  output logic [INDEX_WIDTH-1:0] fill_idx,
  input  logic                   inval_req,
  input  logic [KEY_WIDTH-1:0]   inval_key,
  output logic                   inval_ack,
  output logic                   inval_hit,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   busy,
  output logic [KEY_WIDTH-1:0]   cam_probe_key,
  input  logic                   cam_probe_hit,
  input  logic [INDEX_WIDTH-1:0] cam_probe_idx,
  output logic                   cam_update_en,
  output logic [INDEX_WIDTH-1:0] cam_update_idx,
  output logic [KEY_WIDTH-1:0]   cam_update_key,
  output logic                   cam_update_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL_PROBE,
    ST_INVAL_PROBE,
    ST_FLUSH
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_ENTRIES - 1);

  state_t                 r_state, w_state_next;
  logic [KEY_WIDTH-1:0]   r_key_q, w_key_next;
  logic [INDEX_WIDTH-1:0] r_flush_ptr, w_flush_ptr_next;
  logic [INDEX_WIDTH-1:0] r_rr_ptr, w_rr_ptr_next;
  logic [NUM_ENTRIES-1:0] r_shadow_valid, w_shadow_next;

  logic                   w_any_free;
  logic [INDEX_WIDTH-1:0] w_free_idx;
  logic [INDEX_WIDTH-1:0] w_fill_target;
  logic                   w_evict;

  // Descending scan so the last assignment wins with the lowest free index.
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_shadow_valid[i]) begin
        w_any_free = 1'b1;
        w_free_idx = INDEX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_evict = 1'b0;
    if (cam_probe_hit) begin
      w_fill_target = cam_probe_idx;
    end else if (w_any_free) begin
      w_fill_target = w_free_idx;
    end else begin
      w_fill_target = r_rr_ptr;
      w_evict       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_key_q        <= '0;
      r_flush_ptr    <= '0;
      r_rr_ptr       <= '0;
      r_shadow_valid <= '0;
    end else begin
      r_state        <= w_state_next;
      r_key_q        <= w_key_next;
      r_flush_ptr    <= w_flush_ptr_next;
      r_rr_ptr       <= w_rr_ptr_next;
      r_shadow_valid <= w_shadow_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_key_next       = r_key_q;
    w_flush_ptr_next = r_flush_ptr;
    w_rr_ptr_next    = r_rr_ptr;
    w_shadow_next    = r_shadow_valid;
    fill_ack         = 1'b0;
    fill_idx         = '0;
    inval_ack        = 1'b0;
    inval_hit        = 1'b0;
    flush_done       = 1'b0;
    busy             = (r_state != ST_IDLE);
    cam_probe_key    = r_key_q;
    cam_update_en    = 1'b0;
    cam_update_idx   = '0;
    cam_update_key   = '0;
    cam_update_valid = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (flush_req) begin
          w_state_next = ST_FLUSH;
        end else if (inval_req) begin
          w_key_next   = inval_key;
          w_state_next = ST_INVAL_PROBE;
        end else if (fill_req) begin
          w_key_next   = fill_key;
          w_state_next = ST_FILL_PROBE;
        end
      end

      ST_FILL_PROBE: begin
        cam_update_en                = 1'b1;
        cam_update_idx               = w_fill_target;
        cam_update_key               = r_key_q;
        cam_update_valid             = 1'b1;
        w_shadow_next[w_fill_target] = 1'b1;
        fill_ack                     = 1'b1;
        fill_idx                     = w_fill_target;
        if (w_evict) begin
          w_rr_ptr_next = r_rr_ptr + INDEX_WIDTH'(1);
        end
        w_state_next = ST_IDLE;
      end

      ST_INVAL_PROBE: begin
        inval_ack = 1'b1;
        if (cam_probe_hit) begin
          cam_update_en                = 1'b1;
          cam_update_idx               = cam_probe_idx;
          cam_update_key               = r_key_q;
          cam_update_valid             = 1'b0;
          w_shadow_next[cam_probe_idx] = 1'b0;
          inval_hit                    = 1'b1;
        end
        w_state_next = ST_IDLE;
      end

      ST_FLUSH: begin
        cam_update_en              = 1'b1;
        cam_update_idx             = r_flush_ptr;
        w_shadow_next[r_flush_ptr] = 1'b0;
        if (r_flush_ptr == LAST_IDX) begin
          flush_done       = 1'b1;
          w_flush_ptr_next = '0;
          w_rr_ptr_next    = '0;
          w_state_next     = ST_IDLE;
        end else begin
          w_flush_ptr_next = r_flush_ptr + INDEX_WIDTH'(1);
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

`ifndef SYNTHESIS
  a_probe_hit_shadow: assert property (@(posedge clk) disable iff (reset)
    ((r_state == ST_FILL_PROBE || r_state == ST_INVAL_PROBE) && cam_probe_hit)
      |-> r_shadow_valid[cam_probe_idx]);
  a_fill_ack_req: assert property (@(posedge clk) disable iff (reset)
    fill_ack |-> fill_req);
  a_inval_ack_req: assert property (@(posedge clk) disable iff (reset)
    inval_ack |-> inval_req);
  a_flush_done_req: assert property (@(posedge clk) disable iff (reset)
    flush_done |-> flush_req);
  a_one_completion: assert property (@(posedge clk) disable iff (reset)
    $onehot0({fill_ack, inval_ack, flush_done}));
`endif

endmodule

// File: tb/tb_cam_update_ctrl.sv
// tb/tb_cam_update_ctrl.sv - directed bench for cam_update_ctrl with a behavioural CAM
module tb_cam_update_ctrl;

  localparam int NE = 4;
  localparam int KW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          fill_req, inval_req, flush_req;
  logic [KW-1:0] fill_key, inval_key;
  logic          fill_ack, inval_ack, inval_hit, flush_done, busy;
  logic [IW-1:0] fill_idx;
  logic [KW-1:0] cam_probe_key;
  logic          cam_probe_hit;
  logic [IW-1:0] cam_probe_idx;
  logic          cam_update_en;
  logic [IW-1:0] cam_update_idx;
  logic [KW-1:0] cam_update_key;
  logic          cam_update_valid;

  int n_tests = 0;
  int n_fail  = 0;

  cam_update_ctrl #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .INDEX_WIDTH(IW)) dut (
    .clk              (clk),
    .reset            (reset),
    .fill_req         (fill_req),
    .fill_key         (fill_key),
    .fill_ack         (fill_ack),
    .fill_idx         (fill_idx),
    .inval_req        (inval_req),
    .inval_key        (inval_key),
    .inval_ack        (inval_ack),
    .inval_hit        (inval_hit),
    .flush_req        (flush_req),
    .flush_done       (flush_done),
    .busy             (busy),
    .cam_probe_key    (cam_probe_key),
    .cam_probe_hit    (cam_probe_hit),
    .cam_probe_idx    (cam_probe_idx),
    .cam_update_en    (cam_update_en),
    .cam_update_idx   (cam_update_idx),
    .cam_update_key   (cam_update_key),
    .cam_update_valid (cam_update_valid)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: combinational lookup, lowest matching slot wins.
  logic [KW-1:0] m_key [NE];
  logic [NE-1:0] m_vld;

  always_comb begin
    cam_probe_hit = 1'b0;
    cam_probe_idx = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (m_vld[i] && m_key[i] == cam_probe_key) begin
        cam_probe_hit = 1'b1;
        cam_probe_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_vld <= '0;
    end else if (cam_update_en) begin
      m_key[cam_update_idx] <= cam_update_key;
      m_vld[cam_update_idx] <= cam_update_valid;
    end
  end

  function automatic int count_key(input logic [KW-1:0] k);
    int c = 0;
    for (int i = 0; i < NE; i++) begin
      if (m_vld[i] && m_key[i] == k) c++;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [KW-1:0] key, input int exp_idx);
    fill_key = key;
    fill_req = 1'b1;
    step();
    chk($sformatf("fill_ack[%0h]", key), 32'(fill_ack), 32'd1);
    chk($sformatf("fill_idx[%0h]", key), 32'(fill_idx), 32'(exp_idx));
    chk($sformatf("fill_upd_en[%0h]", key), 32'(cam_update_en), 32'd1);
    chk($sformatf("fill_probe_key[%0h]", key), cam_probe_key, key);
    step();
    fill_req = 1'b0;
    chk($sformatf("fill_ack_pulse[%0h]", key), 32'(fill_ack), 32'd0);
  endtask

  task automatic do_inval(input logic [KW-1:0] key, input logic exp_hit, input int exp_idx);
    inval_key = key;
    inval_req = 1'b1;
    step();
    chk($sformatf("inval_ack[%0h]", key), 32'(inval_ack), 32'd1);
    chk($sformatf("inval_hit[%0h]", key), 32'(inval_hit), 32'(exp_hit));
    chk($sformatf("inval_upd_en[%0h]", key), 32'(cam_update_en), 32'(exp_hit));
    if (exp_hit) begin
      chk($sformatf("inval_upd_idx[%0h]", key), 32'(cam_update_idx), 32'(exp_idx));
      chk($sformatf("inval_upd_valid[%0h]", key), 32'(cam_update_valid), 32'd0);
    end
    step();
    inval_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    fill_req  = 1'b0;
    inval_req = 1'b0;
    flush_req = 1'b0;
    fill_key  = '0;
    inval_key = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fill_ack", 32'(fill_ack), 32'd0);
    chk("rst_upd_en", 32'(cam_update_en), 32'd0);
    chk("rst_shadow", 32'(dut.r_shadow_valid), 32'h0);
    reset = 1'b0;
    step();

    for (int i = 0; i < NE; i++) do_fill(32'hA0 + 32'(i), i);
    chk("shadow_full", 32'(dut.r_shadow_valid), 32'hF);
    chk("rr_after_fills", 32'(dut.r_rr_ptr), 32'd0);

    do_fill(32'hB0, 0);
    chk("rr_after_B0", 32'(dut.r_rr_ptr), 32'd1);
    do_fill(32'hB1, 1);
    chk("rr_after_B1", 32'(dut.r_rr_ptr), 32'd2);

    do_fill(32'hA2, 2);
    chk("rr_after_refresh", 32'(dut.r_rr_ptr), 32'd2);
    chk("no_dup_A2", 32'(count_key(32'hA2)), 32'd1);

    do_inval(32'hA2, 1'b1, 2);
    chk("shadow_after_inval", 32'(dut.r_shadow_valid), 32'hB);
    do_inval(32'hDEAD, 1'b0, 0);
    do_fill(32'hC0, 2);
    chk("rr_after_C0", 32'(dut.r_rr_ptr), 32'd2);

    // Three simultaneous requests: flush, then inval, then fill.
    inval_key = 32'hB1;
    fill_key  = 32'hD0;
    flush_req = 1'b1;
    inval_req = 1'b1;
    fill_req  = 1'b1;
    for (int i = 0; i < NE; i++) begin
      step();
      chk($sformatf("flush_upd_en[%0d]", i), 32'(cam_update_en), 32'd1);
      chk($sformatf("flush_upd_idx[%0d]", i), 32'(cam_update_idx), 32'(i));
      chk($sformatf("flush_upd_valid[%0d]", i), 32'(cam_update_valid), 32'd0);
      chk($sformatf("flush_done[%0d]", i), 32'(flush_done), 32'(i == NE - 1));
      chk($sformatf("flush_no_ack[%0d]", i), 32'(inval_ack | fill_ack), 32'd0);
    end
    step();
    flush_req = 1'b0;
    chk("post_flush_shadow", 32'(dut.r_shadow_valid), 32'h0);
    chk("post_flush_rr", 32'(dut.r_rr_ptr), 32'd0);
    chk("post_flush_busy", 32'(busy), 32'd0);
    step();
    chk("prio_inval_ack", 32'(inval_ack), 32'd1);
    chk("prio_inval_hit", 32'(inval_hit), 32'd0);
    chk("prio_fill_waits", 32'(fill_ack), 32'd0);
    step();
    inval_req = 1'b0;
    step();
    chk("prio_fill_ack", 32'(fill_ack), 32'd1);
    chk("prio_fill_idx", 32'(fill_idx), 32'd0);
    step();
    fill_req = 1'b0;

    // Reset during the second flush cycle.
    flush_req = 1'b1;
    step();
    chk("abort_flush_cyc1", 32'(cam_update_idx), 32'd0);
    step();
    chk("abort_flush_cyc2", 32'(cam_update_idx), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_upd_en", 32'(cam_update_en), 32'd0);
    chk("abort_shadow", 32'(dut.r_shadow_valid), 32'h0);
    flush_req = 1'b0;
    step();
    chk("abort_no_done", 32'(flush_done), 32'd0);
    reset = 1'b0;
    step();
    do_fill(32'hE0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
